// File: rtl/spi_reg_bank.sv
// spi_reg_bank: register bank behind the SPI slave (CTRL regs, CMD pulse, STATUS, WR_CNT, ERR, ID)
// Ports: clk/rst (sync, active-high); rx_wr/rx_addr/rx_data write strobe from the slave
//        (rx_addr[7]=1 write, [6:0] offset); tx_data registered read data of rx_addr[6:0];
//        status_in chip status; reg_out flattened CTRL regs; start_pulse one-cycle CMD pulse.
// Optional: define SPI_REG_LOCK_EN to add the LOCK register at offset 0x24.
module spi_reg_bank #(
    parameter int         NUM_REGS = 16,
    parameter logic [7:0] ID_VAL   = 8'hC5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_wr,
    input  logic [7:0]            rx_addr,
    input  logic [7:0]            rx_data,
    output logic [7:0]            tx_data,
    input  logic [7:0]            status_in,
    output logic [NUM_REGS*8-1:0] reg_out,
    output logic                  start_pulse
);
    localparam int         AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0] NREGS = 7'(NUM_REGS);

    logic [NUM_REGS-1:0][7:0] r_ctrl;
    logic [7:0]               r_status;
    logic [7:0]               r_wr_cnt;
    logic [1:0]               r_err;
    logic                     r_start;
    logic [7:0]               r_tx;
    logic [6:0]               w_off;
    logic                     w_acc;
    logic                     w_is_ctrl;
    logic                     w_locked;
    logic                     w_lock_wr;
    logic                     w_ctrl_wr;
    logic                     w_cmd_wr;
    logic                     w_bad_wr;
    logic                     w_lock_err;
    logic                     w_clr;
    logic [7:0]               w_rd;

    assign w_off      = rx_addr[6:0];
    assign w_acc      = rx_wr & rx_addr[7];
    assign w_is_ctrl  = w_off < NREGS;
    assign w_ctrl_wr  = w_acc & w_is_ctrl & ~w_locked;
    assign w_lock_err = w_acc & w_is_ctrl & w_locked;
    assign w_cmd_wr   = w_acc & (w_off == 7'h20);
    assign w_bad_wr   = w_acc & ~w_is_ctrl & ~w_cmd_wr & ~w_lock_wr;
    // clear takes priority over the increment of the same CMD write
    assign w_clr      = w_cmd_wr & rx_data[1];

`ifdef SPI_REG_LOCK_EN
    logic r_lock;
    assign w_locked  = r_lock;
    assign w_lock_wr = w_acc & (w_off == 7'h24);
    always_ff @(posedge clk) begin
        if (rst)
            r_lock <= 1'b1;
        else if (w_lock_wr)
            r_lock <= (rx_data != 8'hA5);
    end
`else
    assign w_locked  = 1'b0;
    assign w_lock_wr = 1'b0;
`endif

    // read mux sees pre-write contents, so a write reloads tx_data with old data
    always_comb begin
        w_rd = 8'h00;
        if (w_is_ctrl)
            w_rd = r_ctrl[w_off[AW-1:0]];
        else if (w_off == 7'h21)
            w_rd = r_status;
        else if (w_off == 7'h22)
            w_rd = r_wr_cnt;
        else if (w_off == 7'h23)
            w_rd = {6'b0, r_err};
        else if (w_off == 7'h7F)
            w_rd = ID_VAL;
`ifdef SPI_REG_LOCK_EN
        else if (w_off == 7'h24)
            w_rd = {7'b0, r_lock};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= '0;
            r_status <= '0;
            r_wr_cnt <= '0;
            r_err    <= '0;
            r_start  <= 1'b0;
            r_tx     <= '0;
        end else begin
            r_status <= status_in;
            r_tx     <= w_rd;
            r_start  <= w_cmd_wr & rx_data[0];
            if (w_ctrl_wr)
                r_ctrl[w_off[AW-1:0]] <= rx_data;
            if (w_clr)
                r_wr_cnt <= 8'h00;
            else if (w_ctrl_wr | w_cmd_wr | w_lock_wr)
                r_wr_cnt <= r_wr_cnt + 8'd1;
            r_err <= w_clr ? 2'b00 : (r_err | {w_lock_err, w_bad_wr});
        end
    end

    assign tx_data     = r_tx;
    assign reg_out     = r_ctrl;
    assign start_pulse = r_start;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: directed self-checking bench for spi_reg_bank
module tb_spi_reg_bank;
    localparam int NUM_REGS = 16;

    logic                  clk;
    logic                  rst;
    logic                  rx_wr;
    logic [7:0]            rx_addr;
    logic [7:0]            rx_data;
    logic [7:0]            tx_data;
    logic [7:0]            status_in;
    logic [NUM_REGS*8-1:0] reg_out;
    logic                  start_pulse;
    int                    n_checks;
    int                    n_errors;

    spi_reg_bank #(.NUM_REGS(NUM_REGS), .ID_VAL(8'hC5)) dut (
        .clk(clk),
        .rst(rst),
        .rx_wr(rx_wr),
        .rx_addr(rx_addr),
        .rx_data(rx_data),
        .tx_data(tx_data),
        .status_in(status_in),
        .reg_out(reg_out),
        .start_pulse(start_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        rx_wr   = 1'b1;
        rx_addr = a;
        rx_data = d;
        tick();
        rx_wr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a);
        rx_wr   = 1'b0;
        rx_addr = a;
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        rx_wr     = 1'b0;
        rx_addr   = 8'h00;
        rx_data   = 8'h00;
        status_in = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_reg_out", 32'(reg_out == '0), 32'd1);
        chk("rst_start", 32'(start_pulse), 32'd0);
        chk("rst_tx", 32'(tx_data), 32'h00);
        rd(8'h7F);
        chk("id", 32'(tx_data), 32'hC5);
        rd(8'h22);
        chk("rst_wr_cnt", 32'(tx_data), 32'h00);
        rd(8'h23);
        chk("rst_err", 32'(tx_data), 32'h00);
        rd(8'h21);
        chk("rst_status", 32'(tx_data), 32'h00);
        status_in = 8'h3C;
        rd(8'h21);
        chk("status_lag0", 32'(tx_data), 32'h00);
        rd(8'h21);
        chk("status_lag1", 32'(tx_data), 32'h3C);
`ifdef SPI_REG_LOCK_EN
        rd(8'h24);
        chk("lock_rst", 32'(tx_data), 32'h01);
        wr(8'h80, 8'h77);
        chk("locked_reg0", 32'(reg_out[7:0]), 32'h00);
        rd(8'h23);
        chk("locked_err", 32'(tx_data), 32'h02);
        rd(8'h22);
        chk("locked_cnt", 32'(tx_data), 32'h00);
        wr(8'hA4, 8'hA5);
        rd(8'h24);
        chk("unlocked", 32'(tx_data), 32'h00);
        wr(8'h80, 8'h77);
        chk("unlocked_reg0", 32'(reg_out[7:0]), 32'h77);
        rd(8'h22);
        chk("lock_cnt", 32'(tx_data), 32'h02);
`else
        wr(8'hA4, 8'h55);
        rd(8'h24);
        chk("unmapped_24_rd", 32'(tx_data), 32'h00);
        rd(8'h23);
        chk("unmapped_24_err", 32'(tx_data), 32'h01);
`endif
        wr(8'hA0, 8'h02);
        rd(8'h23);
        chk("pre_clr_err", 32'(tx_data), 32'h00);
        wr(8'h83, 8'h5A);
        chk("reg3_wr", 32'(reg_out[31:24]), 32'h5A);
        rd(8'h22);
        chk("cnt_1", 32'(tx_data), 32'h01);
        rd(8'h03);
        chk("reg3_rd", 32'(tx_data), 32'h5A);
        wr(8'hA0, 8'h81);
        chk("start_hi", 32'(start_pulse), 32'd1);
        rd(8'h22);
        chk("start_lo", 32'(start_pulse), 32'd0);
        chk("cnt_2", 32'(tx_data), 32'h02);
        rd(8'h20);
        chk("cmd_rd", 32'(tx_data), 32'h00);
        status_in = 8'h99;
        wr(8'hA1, 8'h11);
        rd(8'h23);
        chk("ro_err", 32'(tx_data), 32'h01);
        rd(8'h22);
        chk("ro_cnt", 32'(tx_data), 32'h02);
        rd(8'h21);
        chk("ro_status", 32'(tx_data), 32'h99);
        wr(8'hA0, 8'h02);
        chk("clr_nostart", 32'(start_pulse), 32'd0);
        rd(8'h22);
        chk("clr_cnt", 32'(tx_data), 32'h00);
        rd(8'h23);
        chk("clr_err", 32'(tx_data), 32'h00);
        wr(8'hA0, 8'h03);
        chk("both_start", 32'(start_pulse), 32'd1);
        rd(8'h22);
        chk("both_cnt", 32'(tx_data), 32'h00);
        for (int i = 0; i < 255; i++)
            wr(8'h80 | 8'(i % NUM_REGS), 8'(i));
        rd(8'h22);
        chk("cnt_ff", 32'(tx_data), 32'hFF);
        wr(8'h8F, 8'hFF);
        rd(8'h22);
        chk("cnt_wrap", 32'(tx_data), 32'h00);
        chk("reg0_last", 32'(reg_out[7:0]), 32'hF0);
        chk("reg15_last", 32'(reg_out[127:120]), 32'hFF);
        rx_wr   = 1'b1;
        rx_addr = 8'h05;
        rx_data = 8'hEE;
        tick();
        rx_wr = 1'b0;
        chk("rdstrobe_tx", 32'(tx_data), 32'hF5);
        chk("rdstrobe_reg5", 32'(reg_out[47:40]), 32'hF5);
        rd(8'h22);
        chk("rdstrobe_cnt", 32'(tx_data), 32'h00);
        rd(8'h23);
        chk("rdstrobe_err", 32'(tx_data), 32'h00);
        wr(8'h81, 8'h11);
        wr(8'h82, 8'h22);
        chk("b2b_reg1", 32'(reg_out[15:8]), 32'h11);
        chk("b2b_reg2", 32'(reg_out[23:16]), 32'h22);
        rd(8'h22);
        chk("b2b_cnt", 32'(tx_data), 32'h02);
        rst = 1'b1;
        wr(8'h84, 8'h99);
        rst = 1'b0;
        chk("midrst_reg_out", 32'(reg_out == '0), 32'd1);
        chk("midrst_tx", 32'(tx_data), 32'h00);
        rd(8'h22);
        chk("midrst_cnt", 32'(tx_data), 32'h00);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
